// File: rtl/ex_mem_pipe.sv
// Elastic EX->MEM writeback register: two-entry skid buffer. Latency is 1 cycle and throughput is 1 record/cycle.
// in_ready is registered, so there is no combinational path from out_ready; the bench-visible forwarding port and stall counter are here too.
module ex_mem_pipe #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int NOP_ADDR   = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_addr,
  input  logic                  in_we,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_addr,
  output logic                  out_we,
  output logic [DATA_W-1:0]     out_data,
  input  logic [REG_ADDR_W-1:0] q_addr,
  output logic                  q_hit,
  output logic [DATA_W-1:0]     q_data,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [REG_ADDR_W-1:0] NOP = REG_ADDR_W'(NOP_ADDR);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic                  we;
    logic [DATA_W-1:0]     dat;
  } rec_t;

  localparam rec_t NOP_REC = '{addr: NOP, we: 1'b0, dat: '0};

  rec_t main_q, skid_q, in_rec;
  logic main_vld, skid_vld;
  logic in_fire, out_fire;

  assign in_rec   = '{addr: in_addr, we: in_we, dat: in_data};
  assign in_ready = ~skid_vld;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign out_valid = main_vld;
  assign out_addr  = main_q.addr;
  assign out_we    = main_vld & main_q.we;
  assign out_data  = main_q.dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld  <= 1'b0;
      skid_vld  <= 1'b0;
      main_q    <= NOP_REC;
      skid_q    <= NOP_REC;
      stall_cnt <= '0;
    end else begin
      // Stall accounting is independent of flush; only reset clears it.
      if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;

      if (flush) begin
        main_vld <= 1'b0;
        skid_vld <= 1'b0;
        main_q   <= NOP_REC;
        skid_q   <= NOP_REC;
      end else if (skid_vld) begin
        if (out_fire) begin
          main_q   <= skid_q;
          skid_vld <= 1'b0;
        end
      end else if (main_vld) begin
        case ({in_fire, out_fire})
          2'b11: main_q <= in_rec;
          2'b10: begin
            skid_q   <= in_rec;
            skid_vld <= 1'b1;
          end
          2'b01: main_vld <= 1'b0;
          default: ;
        endcase
      end else if (in_fire) begin
        main_q   <= in_rec;
        main_vld <= 1'b1;
      end
    end
  end

  // Forwarding: the skid entry is the younger record, so it wins on a double match.
  logic q_ok, main_hit, skid_hit;

  assign q_ok     = (q_addr != NOP);
  assign main_hit = q_ok & main_vld & main_q.we & (main_q.addr == q_addr);
  assign skid_hit = q_ok & skid_vld & skid_q.we & (skid_q.addr == q_addr);
  assign q_hit    = main_hit | skid_hit;

  always_comb begin
    q_data = '0;
    if (skid_hit)      q_data = skid_q.dat;
    else if (main_hit) q_data = main_q.dat;
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: vector table for streaming, backpressure, forwarding and flush,
// plus hand-written sequences for reset values and stall-counter saturation.
module tb_ex_mem_pipe;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int NV = 21;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, in_we;
  logic [AW-1:0] in_addr, out_addr, q_addr;
  logic [DW-1:0] in_data, out_data, q_data;
  logic          out_valid, out_ready, out_we, q_hit;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_pipe #(.REG_ADDR_W(AW), .DATA_W(DW), .NOP_ADDR(0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_we(in_we), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_we(out_we), .out_data(out_data),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic          fl, iv;
    logic [AW-1:0] ia;
    logic          iwe;
    logic [DW-1:0] id;
    logic          ordy;
    logic [AW-1:0] qa;
    logic          ov;
    logic [AW-1:0] oa;
    logic          owe;
    logic [DW-1:0] od;
    logic          ir;
    logic [CW-1:0] cnt;
    logic          qh;
    logic [DW-1:0] qd;
  } vec_t;

  vec_t v[NV];

  function automatic vec_t mk(input int fl, input int iv, input int ia, input int iwe, input int id,
                              input int ordy, input int qa, input int ov, input int oa, input int owe,
                              input int od, input int ir, input int cnt, input int qh, input int qd);
    vec_t r;
    r.fl = fl[0];  r.iv = iv[0];  r.ia = ia[AW-1:0]; r.iwe = iwe[0]; r.id = id;
    r.ordy = ordy[0]; r.qa = qa[AW-1:0];
    r.ov = ov[0];  r.oa = oa[AW-1:0]; r.owe = owe[0]; r.od = od;
    r.ir = ir[0];  r.cnt = cnt[CW-1:0]; r.qh = qh[0]; r.qd = qd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input int i, input vec_t e);
    chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(e.ov));
    chk($sformatf("v%0d out_addr", i),  32'(out_addr),  32'(e.oa));
    chk($sformatf("v%0d out_we", i),    32'(out_we),    32'(e.owe));
    chk($sformatf("v%0d out_data", i),  out_data,       e.od);
    chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(e.ir));
    chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(e.cnt));
    chk($sformatf("v%0d q_hit", i),     32'(q_hit),     32'(e.qh));
    chk($sformatf("v%0d q_data", i),    q_data,         e.qd);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_we"},    32'(out_we),    32'd0);
    chk({tag, " out_addr"},  32'(out_addr),  32'd0);
    chk({tag, " out_data"},  out_data,       32'd0);
    chk({tag, " in_ready"},  32'(in_ready),  32'd1);
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'd0);
    chk({tag, " q_hit"},     32'(q_hit),     32'd0);
    chk({tag, " q_data"},    q_data,         32'd0);
  endtask

  initial begin
    //        fl iv ia we id     or qa   ov oa we od     ir cnt qh qd   (outputs after the edge)
    v[0]  = mk(0, 1, 1, 1, 'h11, 1, 1,   1, 1, 1, 'h11, 1, 0, 1, 'h11);
    v[1]  = mk(0, 1, 2, 1, 'h22, 1, 1,   1, 2, 1, 'h22, 1, 0, 0, 0);
    v[2]  = mk(0, 1, 3, 1, 'h33, 1, 3,   1, 3, 1, 'h33, 1, 0, 1, 'h33);
    v[3]  = mk(0, 1, 4, 1, 'h44, 1, 0,   1, 4, 1, 'h44, 1, 0, 0, 0);
    v[4]  = mk(0, 0, 0, 0, 0,    1, 4,   0, 4, 0, 'h44, 1, 0, 0, 0);
    v[5]  = mk(0, 1, 3, 1, 'hA,  0, 3,   1, 3, 1, 'hA,  1, 0, 1, 'hA);
    v[6]  = mk(0, 1, 4, 1, 'hB,  0, 4,   1, 3, 1, 'hA,  0, 1, 1, 'hB);
    v[7]  = mk(0, 1, 5, 1, 'hC,  0, 5,   1, 3, 1, 'hA,  0, 2, 0, 0);
    v[8]  = mk(0, 1, 5, 1, 'hC,  1, 3,   1, 4, 1, 'hB,  1, 2, 0, 0);
    v[9]  = mk(0, 1, 5, 1, 'hC,  1, 4,   1, 5, 1, 'hC,  1, 2, 0, 0);
    v[10] = mk(0, 0, 0, 0, 0,    1, 5,   0, 5, 0, 'hC,  1, 2, 0, 0);
    v[11] = mk(0, 1, 5, 1, 'h10, 0, 5,   1, 5, 1, 'h10, 1, 2, 1, 'h10);
    v[12] = mk(0, 1, 5, 1, 'h20, 0, 5,   1, 5, 1, 'h10, 0, 3, 1, 'h20);
    v[13] = mk(0, 0, 0, 0, 0,    1, 5,   1, 5, 1, 'h20, 1, 3, 1, 'h20);
    v[14] = mk(0, 1, 0, 1, 'h77, 1, 0,   1, 0, 1, 'h77, 1, 3, 0, 0);
    v[15] = mk(0, 1, 6, 0, 'h66, 1, 6,   1, 6, 0, 'h66, 1, 3, 0, 0);
    v[16] = mk(0, 1, 7, 0, 'h70, 0, 7,   1, 6, 0, 'h66, 0, 4, 0, 0);
    v[17] = mk(1, 1, 9, 1, 'h99, 0, 9,   0, 0, 0, 0,    1, 5, 0, 0);
    v[18] = mk(0, 0, 0, 0, 0,    1, 9,   0, 0, 0, 0,    1, 5, 0, 0);
    v[19] = mk(0, 1, 8, 1, 'h88, 0, 8,   1, 8, 1, 'h88, 1, 5, 1, 'h88);
    v[20] = mk(1, 1, 9, 1, 'h99, 0, 9,   0, 0, 0, 0,    1, 6, 0, 0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_addr = '0; in_we = 1'b0;
    in_data = '0; out_ready = 1'b0; q_addr = 5'd3;
    @(posedge clk); #1;
    chk_reset("reset0");

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      flush = v[i].fl; in_valid = v[i].iv; in_addr = v[i].ia; in_we = v[i].iwe;
      in_data = v[i].id; out_ready = v[i].ordy; q_addr = v[i].qa;
      @(posedge clk); #1;
      chk_vec(i, v[i]);
      @(negedge clk);
    end

    // Saturation: fresh reset, one record parked with out_ready low for 20 cycles.
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_addr = 5'd2; in_we = 1'b1; in_data = 32'h55; q_addr = 5'd2;
    @(posedge clk); #1;
    chk("sat load out_valid", 32'(out_valid), 32'd1);
    chk("sat load stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("sat stall_cnt 14", 32'(stall_cnt), 32'd14);
    repeat (6) @(posedge clk);
    #1;
    chk("sat stall_cnt 15", 32'(stall_cnt), 32'd15);
    chk("sat out_addr", 32'(out_addr), 32'd2);
    chk("sat q_data", q_data, 32'h55);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush keeps stall_cnt", 32'(stall_cnt), 32'd15);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush q_hit", 32'(q_hit), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b1; in_addr = 5'd2; rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("reset1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
